// File: rtl/seven_seg_pkg.sv
// Shared constants, FSM encoding and the anode one-hot helper for the
// seven-segment scanner.
package seven_seg_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int DIGITS_DEF = 8;
    localparam int IDX_W      = $clog2(DIGITS_DEF);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] DRIVE = 2'd2;

    // One-hot anode pattern for digit idx; width follows the package digit count.
    function automatic logic [DIGITS_DEF-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = {{(DIGITS_DEF-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/seven_seg_slot_timer.sv
// Slot counter (cnt) and digit index (idx) for the scanner; flags the last
// cycle of a slot and the last cycle of a whole frame.
module seven_seg_slot_timer
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = DIGITS_DEF,
    parameter int SLOT_CYC   = 1024,
    parameter int CNT_W      = 10,
    parameter int IW         = IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    output logic [CNT_W-1:0] cnt,
    output logic [IW-1:0]    idx,
    output logic             slot_end,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYC - 1);
    localparam logic [IW-1:0]    IDX_LAST = IW'(NUM_DIGITS - 1);

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // clear holds both counters at zero so a re-enabled scan restarts at slot 0.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
            idx <= '0;
        end else if (run) begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 8-digit scanner: pending/active display registers, scan FSM
// with a leading blank gap per slot, and registered decoder-side outputs.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = DIGITS_DEF,
    parameter int SLOT_CYC   = 1024,
    parameter int BLANK_CYC  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable_i,
    input  logic                           load_i,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] data_i,
    input  logic [NUM_DIGITS-1:0]          dp_i,
    input  logic [NUM_DIGITS-1:0]          en_mask_i,
    output logic [NIBBLE_W-1:0]            digit_o,
    output logic [NUM_DIGITS-1:0]          an_sel_o,
    output logic                           dp_o,
    output logic                           frame_o,
    output logic                           busy_o
);

    localparam int CNT_W = $clog2(SLOT_CYC);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

    logic [1:0]                     state;
    logic [CNT_W-1:0]               cnt;
    logic [CNT_W-1:0]               cnt_next;
    logic [IDX_W-1:0]               idx;
    logic                           slot_end;
    logic                           frame_end;
    logic                           run;
    logic                           commit;
    logic [NIBBLE_W*NUM_DIGITS-1:0] pend_data;
    logic [NIBBLE_W*NUM_DIGITS-1:0] act_data;
    logic [NUM_DIGITS-1:0]          pend_dp;
    logic [NUM_DIGITS-1:0]          act_dp;
    logic [NUM_DIGITS-1:0]          pend_mask;
    logic [NUM_DIGITS-1:0]          act_mask;

    assign run      = enable_i && (state != IDLE);
    assign commit   = run && frame_end;
    assign cnt_next = slot_end ? '0 : cnt + 1'b1;

    seven_seg_slot_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SLOT_CYC   (SLOT_CYC),
        .CNT_W      (CNT_W),
        .IW         (IDX_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (!enable_i),
        .run       (run),
        .cnt       (cnt),
        .idx       (idx),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

    // State tracks where the counters will be after this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (!enable_i) begin
            state <= IDLE;
        end else if (state == IDLE) begin
            state <= (BLANK_LIM != '0) ? BLANK : DRIVE;
        end else begin
            state <= (cnt_next < BLANK_LIM) ? BLANK : DRIVE;
        end
    end

    // A load on the commit edge bypasses pending so it is never a frame late.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_data <= '0;
            pend_dp   <= '0;
            pend_mask <= '0;
            act_data  <= '0;
            act_dp    <= '0;
            act_mask  <= '0;
            busy_o    <= 1'b0;
        end else begin
            if (load_i) begin
                pend_data <= data_i;
                pend_dp   <= dp_i;
                pend_mask <= en_mask_i;
            end
            if (commit) begin
                act_data <= load_i ? data_i    : pend_data;
                act_dp   <= load_i ? dp_i      : pend_dp;
                act_mask <= load_i ? en_mask_i : pend_mask;
                busy_o   <= 1'b0;
            end else if (load_i) begin
                busy_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_o  <= '0;
            an_sel_o <= '0;
            dp_o     <= 1'b0;
            frame_o  <= 1'b0;
        end else begin
            frame_o  <= commit;
            digit_o  <= run ? act_data[idx*NIBBLE_W +: NIBBLE_W] : '0;
            dp_o     <= run && act_dp[idx] && act_mask[idx];
            an_sel_o <= (run && (state == DRIVE) && act_mask[idx]) ? onehot(idx) : '0;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with SLOT_CYC=4, BLANK_CYC=1: stimulus
// queues expected lit cycles, a negedge monitor pops and compares them.
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_i;
    logic        load_i;
    logic [31:0] data_i;
    logic [7:0]  dp_i;
    logic [7:0]  en_mask_i;
    logic [3:0]  digit_o;
    logic [7:0]  an_sel_o;
    logic        dp_o;
    logic        frame_o;
    logic        busy_o;

    int checks    = 0;
    int errors    = 0;
    int frame_cnt = 0;
    int p         = 0;

    // Entry layout: {an_sel[7:0], digit[3:0], dp}
    logic [12:0] exp_q[$];

    seven_seg_scan #(
        .NUM_DIGITS (8),
        .SLOT_CYC   (4),
        .BLANK_CYC  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable_i  (enable_i),
        .load_i    (load_i),
        .data_i    (data_i),
        .dp_i      (dp_i),
        .en_mask_i (en_mask_i),
        .digit_o   (digit_o),
        .an_sel_o  (an_sel_o),
        .dp_o      (dp_o),
        .frame_o   (frame_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        p++;
    endtask

    task automatic goto_p(input int t);
        while (p < t) tick();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] m);
        data_i    = d;
        dp_i      = dp;
        en_mask_i = m;
        load_i    = 1'b1;
    endtask

    // Three lit cycles per shown digit per frame; reps lets a truncated slot be queued.
    task automatic push_slots(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] m,
                              input int lo, input int hi, input int reps);
        logic [7:0] an;
        logic [3:0] nib;
        for (int k = lo; k <= hi; k++) begin
            if (m[k]) begin
                an  = 8'd1 << k;
                nib = d[k*4 +: 4];
                for (int r = 0; r < reps; r++) exp_q.push_back({an, nib, dp[k]});
            end
        end
    endtask

    always @(negedge clk) begin
        logic [12:0] e;
        if (frame_o === 1'b1) frame_cnt++;
        if (an_sel_o != 8'd0) begin
            checks++;
            if (!$onehot(an_sel_o)) begin
                errors++;
                $display("FAIL an_onehot: got %h expected one-hot", an_sel_o);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL lit_unexpected: got %h expected no lit digit", {an_sel_o, digit_o, dp_o});
            end else begin
                e = exp_q.pop_front();
                if ({an_sel_o, digit_o, dp_o} !== e) begin
                    errors++;
                    $display("FAIL lit_cycle: got %h expected %h", {an_sel_o, digit_o, dp_o}, e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; enable_i = 1'b0; load_i = 1'b0;
        data_i = '0; dp_i = '0; en_mask_i = '0;
        repeat (3) @(posedge clk);
        #1;
        sample();
        check("reset_outputs", 32'({digit_o, an_sel_o, dp_o, frame_o, busy_o}), 32'd0);

        // Frame 1 shows cleared registers; frame 2 shows the first load.
        @(posedge clk); #1;
        rst_n = 1'b1; enable_i = 1'b1;
        drive_load(32'h89ABCDEF, 8'h01, 8'hFF);
        push_slots(32'h89ABCDEF, 8'h01, 8'hFF, 0, 7, 3);
        @(posedge clk); #1;
        p = 0;
        load_i = 1'b0;
        sample(); check("busy_after_load", 32'(busy_o), 32'd1);
        goto_p(31); sample(); check("frame_before_commit", 32'(frame_o), 32'd0);
        goto_p(32); sample(); check("frame_at_commit1", 32'(frame_o), 32'd1);
        check("busy_cleared1", 32'(busy_o), 32'd0);

        // Mid-frame load at idx 3: old value finishes, new value from slot 0.
        goto_p(44);
        drive_load(32'h11111111, 8'h00, 8'hFF);
        push_slots(32'h11111111, 8'h00, 8'hFF, 0, 7, 3);
        tick(); load_i = 1'b0;
        sample(); check("busy_mid_frame", 32'(busy_o), 32'd1);
        goto_p(63); sample(); check("busy_until_commit", 32'(busy_o), 32'd1);
        goto_p(64); sample(); check("busy_cleared2", 32'(busy_o), 32'd0);
        check("frame_at_commit2", 32'(frame_o), 32'd1);
        goto_p(65); sample(); check("frame_single_pulse", 32'(frame_o), 32'd0);
        check("frame_count2", 32'(frame_cnt), 32'd2);

        // Mask F0: slots 0-3 stay dark.
        goto_p(70);
        drive_load(32'h76543210, 8'hA0, 8'hF0);
        push_slots(32'h76543210, 8'hA0, 8'hF0, 0, 7, 3);
        tick(); load_i = 1'b0;

        // Load on the commit edge goes straight to active.
        goto_p(127);
        drive_load(32'hCAFEBABE, 8'h0F, 8'hFF);
        push_slots(32'hCAFEBABE, 8'h0F, 8'hFF, 0, 7, 3);
        tick(); load_i = 1'b0;
        sample(); check("busy_commit_load", 32'(busy_o), 32'd0);
        check("frame_at_commit4", 32'(frame_o), 32'd1);
        goto_p(129); sample(); check("busy_stays_low", 32'(busy_o), 32'd0);

        // Double load while busy: only the second reaches the display.
        goto_p(130);
        drive_load(32'h12345678, 8'h00, 8'hFF);
        tick(); load_i = 1'b0;
        sample(); check("busy_first_load", 32'(busy_o), 32'd1);
        goto_p(140);
        drive_load(32'h0F0F0F0F, 8'h80, 8'hFF);
        push_slots(32'h0F0F0F0F, 8'h80, 8'hFF, 0, 7, 3);
        push_slots(32'h0F0F0F0F, 8'h80, 8'hFF, 0, 0, 3);
        push_slots(32'h0F0F0F0F, 8'h80, 8'hFF, 1, 1, 1);
        tick(); load_i = 1'b0;

        // Disable during slot 1 DRIVE of the next frame.
        goto_p(198);
        enable_i = 1'b0;
        tick(); sample();
        check("an_off_after_disable", 32'(an_sel_o), 32'd0);
        check("frame_count_disable", 32'(frame_cnt), 32'd6);
        tick(); sample();
        check("idle_digit_zero", 32'(digit_o), 32'd0);
        goto_p(203);
        enable_i = 1'b1;
        push_slots(32'h0F0F0F0F, 8'h80, 8'hFF, 0, 7, 3);
        push_slots(32'h0F0F0F0F, 8'h80, 8'hFF, 0, 4, 3);
        tick(); p = 0;
        tick(); sample();
        check("restart_blank_an", 32'(an_sel_o), 32'd0);
        check("restart_blank_digit", 32'(digit_o), 32'hF);
        tick(); sample();
        check("restart_first_anode", 32'(an_sel_o), 32'h01);

        // Reset at idx 5 of the following frame.
        goto_p(53);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sample();
        check("midframe_reset_outputs", 32'({digit_o, an_sel_o, dp_o, frame_o, busy_o}), 32'd0);
        check("frame_count_reset", 32'(frame_cnt), 32'd7);
        goto_p(86); sample(); check("frame_after_reset_early", 32'(frame_o), 32'd0);
        goto_p(87); sample(); check("frame_after_reset", 32'(frame_o), 32'd1);
        goto_p(90); sample();
        check("frame_count_final", 32'(frame_cnt), 32'd8);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
